// File: rtl/parser_pipe_n.sv
// Cascaded parser pipeline: NUM_LAYERS parser_layer stages with per-layer bypass
// delay lines, top-level packet counters and a timeout-guarded config read FSM.

module parser_layer #(
  parameter int HEAD_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int META_WIDTH = 16,
  parameter int LAYER_LAT  = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_rule_wren,
  input  logic                             i_rule_rden,
  input  logic [23:0]                      i_rule_addr,
  input  logic [31:0]                      i_rule_wdata,
  output logic                             o_rule_rdata_valid,
  output logic [31:0]                      o_rule_rdata,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]  i_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0]  i_meta,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta
);
  localparam int HW = HEAD_WIDTH + TAG_WIDTH;
  localparam int MW = META_WIDTH + TAG_WIDTH;

  logic [31:0]         rule_r;
  logic [HW-1:0]       head_pipe_r [LAYER_LAT];
  logic [MW-1:0]       meta_pipe_r [LAYER_LAT];
  logic [HW-1:0]       head_in_s;
  logic                reg_hit_s;

  // The layer's only rule: XOR the header payload with the rule word; tag untouched.
  assign head_in_s = {i_head[HW-1:HEAD_WIDTH], i_head[HEAD_WIDTH-1:0] ^ HEAD_WIDTH'(rule_r)};
  assign reg_hit_s = (i_rule_addr == 24'd0);
  assign o_head    = head_pipe_r[LAYER_LAT-1];
  assign o_meta    = meta_pipe_r[LAYER_LAT-1];

  // Rule register; reads of any other offset are never answered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rule_r             <= 32'd0;
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= 32'd0;
    end else begin
      if (i_rule_wren && reg_hit_s) rule_r <= i_rule_wdata;
      o_rule_rdata_valid <= i_rule_rden && reg_hit_s;
      if (i_rule_rden && reg_hit_s) o_rule_rdata <= rule_r;
    end
  end

  // Fixed-latency head/meta pipeline.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int j = 0; j < LAYER_LAT; j++) begin
        head_pipe_r[j] <= '0;
        meta_pipe_r[j] <= '0;
      end
    end else begin
      head_pipe_r[0] <= head_in_s;
      meta_pipe_r[0] <= i_meta;
      for (int j = 1; j < LAYER_LAT; j++) begin
        head_pipe_r[j] <= head_pipe_r[j-1];
        meta_pipe_r[j] <= meta_pipe_r[j-1];
      end
    end
  end
endmodule

module parser_pipe_n #(
  parameter int NUM_LAYERS = 3,
  parameter int LAYER_LAT  = 2,
  parameter int RD_TIMEOUT = 64,
  parameter int HEAD_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int META_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_rule_wren,
  input  logic                             i_rule_rden,
  input  logic [31:0]                      i_rule_addr,
  input  logic [31:0]                      i_rule_wdata,
  output logic                             o_rule_rdata_valid,
  output logic [31:0]                      o_rule_rdata,
  input  logic [HEAD_WIDTH+TAG_WIDTH-1:0]  i_head,
  input  logic [META_WIDTH+TAG_WIDTH-1:0]  i_meta,
  output logic [HEAD_WIDTH+TAG_WIDTH-1:0]  o_head,
  output logic [META_WIDTH+TAG_WIDTH-1:0]  o_meta
);
  localparam int HW = HEAD_WIDTH + TAG_WIDTH;
  localparam int MW = META_WIDTH + TAG_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} rd_state_t;

  rd_state_t             state_r;
  logic [2:0]            tgt_r;
  logic [9:0]            tmo_cnt_r;
  logic [NUM_LAYERS-1:0] bypass_r;
  logic [31:0]           in_pkt_r, out_pkt_r, tmo_pkt_r;

  logic [2:0]            sel_s;
  logic [3:0]            off_s;
  logic                  top_wr_s, tmo_fire_s, sel_rvalid_s, unused_addr_s;
  logic [31:0]           top_rdata_s, sel_rdata_s;
  logic [NUM_LAYERS-1:0] layer_wren_s, layer_rden_s, layer_rvalid_s;
  logic [31:0]           layer_rdata_s [NUM_LAYERS];
  logic [HW-1:0]         head_s [NUM_LAYERS+1];
  logic [MW-1:0]         meta_s [NUM_LAYERS+1];

  assign sel_s         = i_rule_addr[26:24];
  assign off_s         = i_rule_addr[3:0];
  assign top_wr_s      = i_rule_wren && (sel_s == 3'd7);
  assign unused_addr_s = ^i_rule_addr[31:27];
  assign head_s[0]     = i_head;
  assign meta_s[0]     = i_meta;
  assign o_head        = head_s[NUM_LAYERS];
  assign o_meta        = meta_s[NUM_LAYERS];

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    logic [HW-1:0] lay_head_s;
    logic [MW-1:0] lay_meta_s;
    logic [HW-1:0] hdly_r [LAYER_LAT];
    logic [MW-1:0] mdly_r [LAYER_LAT];

    // Layer reads are only launched from IDLE so a busy FSM never leaves a stray response.
    assign layer_wren_s[k] = i_rule_wren && (sel_s == 3'(k));
    assign layer_rden_s[k] = i_rule_rden && (state_r == ST_IDLE) && (sel_s == 3'(k));

    parser_layer #(
      .HEAD_WIDTH (HEAD_WIDTH),
      .TAG_WIDTH  (TAG_WIDTH),
      .META_WIDTH (META_WIDTH),
      .LAYER_LAT  (LAYER_LAT)
    ) u_layer (
      .i_clk              (i_clk),
      .i_rst_n            (i_rst_n),
      .i_rule_wren        (layer_wren_s[k]),
      .i_rule_rden        (layer_rden_s[k]),
      .i_rule_addr        (i_rule_addr[23:0]),
      .i_rule_wdata       (i_rule_wdata),
      .o_rule_rdata_valid (layer_rvalid_s[k]),
      .o_rule_rdata       (layer_rdata_s[k]),
      .i_head             (head_s[k]),
      .i_meta             (meta_s[k]),
      .o_head             (lay_head_s),
      .o_meta             (lay_meta_s)
    );

    // Bypass delay line matching the layer latency, so the mask never changes timing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int j = 0; j < LAYER_LAT; j++) begin
          hdly_r[j] <= '0;
          mdly_r[j] <= '0;
        end
      end else begin
        hdly_r[0] <= head_s[k];
        mdly_r[0] <= meta_s[k];
        for (int j = 1; j < LAYER_LAT; j++) begin
          hdly_r[j] <= hdly_r[j-1];
          mdly_r[j] <= mdly_r[j-1];
        end
      end
    end

    assign head_s[k+1] = bypass_r[k] ? hdly_r[LAYER_LAT-1] : lay_head_s;
    assign meta_s[k+1] = bypass_r[k] ? mdly_r[LAYER_LAT-1] : lay_meta_s;
  end

  // Top register read mux.
  always_comb begin
    case (off_s)
      4'd0:    top_rdata_s = {{(32-NUM_LAYERS){1'b0}}, bypass_r};
      4'd1:    top_rdata_s = in_pkt_r;
      4'd2:    top_rdata_s = out_pkt_r;
      4'd3:    top_rdata_s = tmo_pkt_r;
      default: top_rdata_s = 32'd0;
    endcase
  end

  // Pick the response of the layer being waited on; other layers are ignored.
  always_comb begin
    sel_rvalid_s = 1'b0;
    sel_rdata_s  = 32'd0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      sel_rvalid_s = sel_rvalid_s | (layer_rvalid_s[k] & (tgt_r == 3'(k)));
      sel_rdata_s  = sel_rdata_s | (layer_rdata_s[k] & {32{tgt_r == 3'(k)}});
    end
  end

  // A layer answer arriving in the final WAIT cycle wins over the timeout.
  assign tmo_fire_s = (state_r == ST_WAIT) && !sel_rvalid_s &&
                      (tmo_cnt_r == 10'(RD_TIMEOUT - 1));

  // Bypass mask and counters; a clearing write wins over a same-cycle increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bypass_r  <= '0;
      in_pkt_r  <= 32'd0;
      out_pkt_r <= 32'd0;
      tmo_pkt_r <= 32'd0;
    end else begin
      if (top_wr_s && off_s == 4'd0) bypass_r <= i_rule_wdata[NUM_LAYERS-1:0];
      if (top_wr_s && off_s == 4'd1)  in_pkt_r <= 32'd0;
      else if (i_meta[MW-1])          in_pkt_r <= in_pkt_r + 32'd1;
      if (top_wr_s && off_s == 4'd2)  out_pkt_r <= 32'd0;
      else if (o_meta[MW-1])          out_pkt_r <= out_pkt_r + 32'd1;
      if (top_wr_s && off_s == 4'd3)  tmo_pkt_r <= 32'd0;
      else if (tmo_fire_s)            tmo_pkt_r <= tmo_pkt_r + 32'd1;
    end
  end

  // Config read FSM; o_rule_rdata_valid is high exactly while in RESP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r            <= ST_IDLE;
      tgt_r              <= 3'd0;
      tmo_cnt_r          <= 10'd0;
      o_rule_rdata_valid <= 1'b0;
      o_rule_rdata       <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_rule_rdata_valid <= 1'b0;
          if (i_rule_rden) begin
            if (sel_s < 3'(NUM_LAYERS)) begin
              tgt_r     <= sel_s;
              tmo_cnt_r <= 10'd0;
              state_r   <= ST_WAIT;
            end else begin
              o_rule_rdata       <= (sel_s == 3'd7) ? top_rdata_s : 32'd0;
              o_rule_rdata_valid <= 1'b1;
              state_r            <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (sel_rvalid_s) begin
            o_rule_rdata       <= sel_rdata_s;
            o_rule_rdata_valid <= 1'b1;
            state_r            <= ST_RESP;
          end else if (tmo_fire_s) begin
            o_rule_rdata       <= 32'hDEAD_BEEF;
            o_rule_rdata_valid <= 1'b1;
            state_r            <= ST_RESP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 10'd1;
          end
        end
        ST_RESP: begin
          o_rule_rdata_valid <= 1'b0;
          state_r            <= ST_IDLE;
        end
        default: begin
          o_rule_rdata_valid <= 1'b0;
          state_r            <= ST_IDLE;
        end
      endcase
    end
  end
endmodule
